muldiv_issue: RTL and testbench

Issue/writeback sequencer that sits directly in front of `uriscv_muldiv_param`. It accepts decoded RV32M requests (funct3, two operands, destination register) into a small FIFO and issues them to the mul/div unit one at a time. It drives the unit's one-hot `inst_*` / single-cycle `valid` protocol, waits for `ready`, and presents the result on a backpressured writeback port. The block guarantees the unit's input contract: one-hot op bits, single-pulse valid, and no valid while stalled.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_req_fifo.sv | 57 +++++
 rtl/muldiv_issue.sv | 144 ++++++++++++++
 tb/tb_muldiv_issue.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M issue/writeback sequencer: funct3 ops, FSM states,
// and the request FIFO entry.
package muldiv_pkg;

  localparam int MULDIV_N   = 16;
  localparam int MULDIV_RDW = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_WB    = 2'd3
  } muldiv_state_e;

  typedef struct packed {
    muldiv_op_e              funct3;
    logic [MULDIV_N-1:0]     ra;
    logic [MULDIV_N-1:0]     rb;
    logic [MULDIV_RDW-1:0]   rd;
  } muldiv_req_t;

  // Bit k of the result selects the op whose funct3 encoding is k
  function automatic logic [7:0] op_onehot(input muldiv_op_e op);
    return 8'd1 << op;
  endfunction

endpackage

// File: rtl/muldiv_req_fifo.sv
// Synchronous request FIFO with occupancy count; push is refused when full,
// pop is ignored when empty.
module muldiv_req_fifo
  import muldiv_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = muldiv_req_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/muldiv_issue.sv
// Issue/writeback sequencer in front of the mul/div unit: queues RV32M requests,
// issues them one at a time with a single-cycle valid, and holds results for writeback.
module muldiv_issue
  import muldiv_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int RDW   = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [2:0]     req_funct3_i,
  input  logic [N-1:0]   req_ra_i,
  input  logic [N-1:0]   req_rb_i,
  input  logic [RDW-1:0] req_rd_i,
  output logic           valid_o,
  output logic           inst_mul_o,
  output logic           inst_mulh_o,
  output logic           inst_mulhsu_o,
  output logic           inst_mulhu_o,
  output logic           inst_div_o,
  output logic           inst_divu_o,
  output logic           inst_rem_o,
  output logic           inst_remu_o,
  output logic [N-1:0]   operand_ra_o,
  output logic [N-1:0]   operand_rb_o,
  input  logic           stall_i,
  input  logic           ready_i,
  input  logic [N-1:0]   result_i,
  output logic           wb_valid_o,
  input  logic           wb_ready_i,
  output logic [RDW-1:0] wb_rd_o,
  output logic [N-1:0]   wb_data_o
);

  typedef struct packed {
    muldiv_op_e     funct3;
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;
    logic [RDW-1:0] rd;
  } req_t;

  req_t                   w_req;
  req_t                   w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_unused;

  muldiv_state_e  r_state;
  logic [7:0]     r_op;
  logic [N-1:0]   r_ra;
  logic [N-1:0]   r_rb;
  logic [RDW-1:0] r_rd;
  logic [RDW-1:0] r_wb_rd;
  logic [N-1:0]   r_wb_data;

  assign w_req.funct3 = muldiv_op_e'(req_funct3_i);
  assign w_req.ra     = req_ra_i;
  assign w_req.rb     = req_rb_i;
  assign w_req.rd     = req_rd_i;
  assign w_unused     = ^w_count;

  muldiv_req_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (req_valid_i),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign req_ready_o = !w_full;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty && !stall_i;

  // valid must drop in the same cycle the unit stalls, so it is gated by stall_i
  assign valid_o       = (r_state == ST_ISSUE) && !stall_i;
  assign inst_mul_o    = r_op[0] & valid_o;
  assign inst_mulh_o   = r_op[1] & valid_o;
  assign inst_mulhsu_o = r_op[2] & valid_o;
  assign inst_mulhu_o  = r_op[3] & valid_o;
  assign inst_div_o    = r_op[4] & valid_o;
  assign inst_divu_o   = r_op[5] & valid_o;
  assign inst_rem_o    = r_op[6] & valid_o;
  assign inst_remu_o   = r_op[7] & valid_o;
  assign operand_ra_o  = r_ra;
  assign operand_rb_o  = r_rb;
  assign wb_valid_o    = (r_state == ST_WB);
  assign wb_rd_o       = r_wb_rd;
  assign wb_data_o     = r_wb_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_op      <= 8'd0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rd      <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_op    <= op_onehot(w_head.funct3);
            r_ra    <= w_head.ra;
            r_rb    <= w_head.rb;
            r_rd    <= w_head.rd;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall_i) r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          // Writes to x0 complete silently
          if (ready_i) begin
            if (r_rd != '0) begin
              r_wb_rd   <= r_rd;
              r_wb_data <= result_i;
              r_state   <= ST_WB;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WB: begin
          if (wb_ready_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_issue.sv
// Self-checking bench for muldiv_issue with a behavioural mul/div unit stub.
module tb_muldiv_issue;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [15:0] req_ra_i, req_rb_i;
  logic [4:0]  req_rd_i;
  logic        valid_o;
  logic        inst_mul_o, inst_mulh_o, inst_mulhsu_o, inst_mulhu_o;
  logic        inst_div_o, inst_divu_o, inst_rem_o, inst_remu_o;
  logic [15:0] operand_ra_o, operand_rb_o;
  logic        stall_i;
  logic        ready_i;
  logic [15:0] result_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [15:0] wb_data_o;
  logic [7:0]  w_inst;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_pulse = 0;
  int          n_viol = 0;
  logic [7:0]  last_inst = 8'd0;
  logic        prev_valid = 1'b0;
  logic [4:0]  wbq_rd[$];
  logic [15:0] wbq_data[$];

  muldiv_issue dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_funct3_i(req_funct3_i),
    .req_ra_i(req_ra_i), .req_rb_i(req_rb_i), .req_rd_i(req_rd_i),
    .valid_o(valid_o),
    .inst_mul_o(inst_mul_o), .inst_mulh_o(inst_mulh_o), .inst_mulhsu_o(inst_mulhsu_o),
    .inst_mulhu_o(inst_mulhu_o), .inst_div_o(inst_div_o), .inst_divu_o(inst_divu_o),
    .inst_rem_o(inst_rem_o), .inst_remu_o(inst_remu_o),
    .operand_ra_o(operand_ra_o), .operand_rb_o(operand_rb_o),
    .stall_i(stall_i), .ready_i(ready_i), .result_i(result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
  );

  assign w_inst = {inst_remu_o, inst_rem_o, inst_divu_o, inst_div_o,
                   inst_mulhu_o, inst_mulhsu_o, inst_mulh_o, inst_mul_o};

  always #5 clk = ~clk;

  // RV32M semantics at 16 bits, including divide-by-zero and overflow results
  function automatic logic [15:0] unit_calc(input logic [7:0] inst, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic signed [15:0] sa, sb;
    sa = a;
    sb = b;
    p = 32'd0;
    if (inst[0]) begin p = {16'd0, a} * {16'd0, b}; return p[15:0]; end
    if (inst[1]) begin p = {{16{a[15]}}, a} * {{16{b[15]}}, b}; return p[31:16]; end
    if (inst[2]) begin p = {{16{a[15]}}, a} * {16'd0, b}; return p[31:16]; end
    if (inst[3]) begin p = {16'd0, a} * {16'd0, b}; return p[31:16]; end
    if (inst[4]) begin
      if (b == 16'd0) return 16'hFFFF;
      if (a == 16'h8000 && b == 16'hFFFF) return 16'h8000;
      return 16'(sa / sb);
    end
    if (inst[5]) return (b == 16'd0) ? 16'hFFFF : a / b;
    if (inst[6]) begin
      if (b == 16'd0) return a;
      if (a == 16'h8000 && b == 16'hFFFF) return 16'h0000;
      return 16'(sa % sb);
    end
    if (inst[7]) return (b == 16'd0) ? a : a % b;
    return 16'hDEAD;
  endfunction

  // Unit stub: accept valid at a clock edge, answer with a one-cycle ready LAT cycles later
  initial begin : unit_model
    logic        s_valid, s_rst, pend;
    logic [7:0]  s_inst;
    logic [15:0] s_a, s_b, pres;
    int          cd;
    ready_i = 1'b0; result_i = 16'd0; pend = 1'b0; cd = 0; pres = 16'd0;
    forever begin
      @(posedge clk);
      s_valid = valid_o; s_rst = rst_i; s_inst = w_inst; s_a = operand_ra_o; s_b = operand_rb_o;
      #1;
      ready_i = 1'b0;
      if (s_rst) pend = 1'b0;
      else begin
        if (pend) begin
          if (cd == 0) begin ready_i = 1'b1; result_i = pres; pend = 1'b0; end
          else cd--;
        end
        if (s_valid) begin pend = 1'b1; cd = LAT; pres = unit_calc(s_inst, s_a, s_b); end
      end
    end
  end

  // Protocol monitor and writeback log
  always @(posedge clk) begin
    if (!rst_i) begin
      if (valid_o) begin
        n_pulse   <= n_pulse + 1;
        last_inst <= w_inst;
      end
      if ((valid_o && (stall_i || $countones(w_inst) != 1 || prev_valid)) ||
          (!valid_o && w_inst != 8'd0) || (wb_valid_o && wb_rd_o == 5'd0))
        n_viol <= n_viol + 1;
      if (wb_valid_o && wb_ready_i) begin
        wbq_rd.push_back(wb_rd_o);
        wbq_data.push_back(wb_data_o);
      end
      prev_valid <= valid_o;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  // Called at a negedge; returns at the negedge after the push edge
  task automatic send(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b, input logic [4:0] rd);
    int k;
    req_valid_i = 1'b1; req_funct3_i = f; req_ra_i = a; req_rb_i = b; req_rd_i = rd;
    k = 0;
    while (!req_ready_o && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) timeout_fail("send");
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_wb(input int target);
    int k;
    k = 0;
    while (wbq_rd.size() < target && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) timeout_fail("wait_wb");
  endtask

  task automatic wait_sig(input string name, input int which);
    int k;
    k = 0;
    while (((which == 0) ? ready_i : (which == 1) ? valid_o : wb_valid_o) !== 1'b1 && k < 200) begin
      @(negedge clk); k++;
    end
    if (k >= 200) timeout_fail(name);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  rd;
    logic [7:0]  inst;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin : main
    int base, p, stable, held;
    logic [4:0]  ord_rd[5];
    logic [15:0] ord_d[5];

    vecs[0]  = '{3'b100, 16'h8000, 16'hFFFF, 5'd2,  8'h10, 16'h8000};
    vecs[1]  = '{3'b101, 16'h1234, 16'h0000, 5'd4,  8'h20, 16'hFFFF};
    vecs[2]  = '{3'b110, 16'h0007, 16'h0000, 5'd5,  8'h40, 16'h0007};
    vecs[3]  = '{3'b011, 16'hFFFF, 16'hFFFF, 5'd6,  8'h08, 16'hFFFE};
    vecs[4]  = '{3'b010, 16'hFFFF, 16'h0002, 5'd7,  8'h04, 16'hFFFF};
    vecs[5]  = '{3'b111, 16'h000A, 16'h0003, 5'd8,  8'h80, 16'h0001};
    vecs[6]  = '{3'b101, 16'h0064, 16'h0007, 5'd9,  8'h20, 16'h000E};
    vecs[7]  = '{3'b100, 16'hFFF9, 16'h0002, 5'd10, 8'h10, 16'hFFFD};
    vecs[8]  = '{3'b110, 16'hFFF9, 16'h0002, 5'd11, 8'h40, 16'hFFFF};
    vecs[9]  = '{3'b001, 16'h7FFF, 16'h7FFF, 5'd12, 8'h02, 16'h3FFF};
    vecs[10] = '{3'b000, 16'h1234, 16'h0010, 5'd13, 8'h01, 16'h2340};

    rst_i = 1'b1; req_valid_i = 1'b0; req_funct3_i = 3'd0; req_ra_i = 16'd0; req_rb_i = 16'd0;
    req_rd_i = 5'd0; stall_i = 1'b0; wb_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    chk("reset_req_ready", req_ready_o, 1);
    chk("reset_valid", valid_o, 0);
    chk("reset_inst", w_inst, 0);
    chk("reset_operands", {operand_ra_o, operand_rb_o}, 0);
    chk("reset_wb_valid", wb_valid_o, 0);
    chk("reset_wb_rd_data", {wb_rd_o, wb_data_o}, 0);

    // MUL 3x5 with issue and writeback latency checks
    p = n_pulse;
    send(3'b000, 16'h0003, 16'h0005, 5'd1);
    chk("lat_t1_valid", valid_o, 0);
    @(negedge clk);
    chk("lat_t2_valid", valid_o, 1);
    chk("lat_t2_inst_mul", w_inst, 8'h01);
    wait_sig("wait_ready", 0);
    chk("wb_before_r1", wb_valid_o, 0);
    @(negedge clk);
    chk("wb_at_r1", wb_valid_o, 1);
    chk("mul_wb_data", wb_data_o, 16'h000F);
    chk("mul_wb_rd", wb_rd_o, 5'd1);
    wait_wb(1);
    chk("mul_pulses", n_pulse - p, 1);

    // Table-driven single operations
    for (int i = 0; i < 11; i++) begin
      base = wbq_rd.size();
      p = n_pulse;
      send(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_wb(base + 1);
      if (wbq_rd.size() > base) begin
        chk($sformatf("vec%0d_data", i), wbq_data[base], vecs[i].exp);
        chk($sformatf("vec%0d_rd", i), wbq_rd[base], vecs[i].rd);
      end
      chk($sformatf("vec%0d_pulses", i), n_pulse - p, 1);
      chk($sformatf("vec%0d_inst", i), last_inst, vecs[i].inst);
    end

    // Fill the FIFO while the unit stalls, then a fifth request must wait for a pop
    ord_rd = '{5'd15, 5'd16, 5'd17, 5'd18, 5'd19};
    ord_d  = '{16'h0006, 16'h0010, 16'h0004, 16'h0001, 16'h0000};
    base = wbq_rd.size();
    stall_i = 1'b1;
    send(3'b000, 16'h0002, 16'h0003, 5'd15);
    send(3'b000, 16'h0004, 16'h0004, 5'd16);
    send(3'b101, 16'h0009, 16'h0002, 5'd17);
    send(3'b111, 16'h0009, 16'h0002, 5'd18);
    chk("full_ready_low", req_ready_o, 0);
    req_valid_i = 1'b1; req_funct3_i = 3'b000; req_ra_i = 16'h0100; req_rb_i = 16'h0100; req_rd_i = 5'd19;
    held = 0;
    repeat (3) begin @(negedge clk); held = held | int'(req_ready_o) | int'(valid_o); end
    chk("full_ready_held", held, 0);
    stall_i = 1'b0;
    send(3'b000, 16'h0100, 16'h0100, 5'd19);
    wait_wb(base + 5);
    for (int i = 0; i < 5; i++) begin
      if (wbq_rd.size() > base + i) begin
        chk($sformatf("order%0d_rd", i), wbq_rd[base + i], ord_rd[i]);
        chk($sformatf("order%0d_data", i), wbq_data[base + i], ord_d[i]);
      end
    end

    // Writeback backpressure holds data/rd and blocks the next issue
    base = wbq_rd.size();
    wb_ready_i = 1'b0;
    send(3'b000, 16'h0007, 16'h0009, 5'd20);
    send(3'b101, 16'h0010, 16'h0004, 5'd21);
    wait_sig("wait_wb_valid", 2);
    p = n_pulse;
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (wb_valid_o !== 1'b1 || wb_data_o !== 16'h003F || wb_rd_o !== 5'd20) stable = 0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_no_issue", n_pulse - p, 0);
    wb_ready_i = 1'b1;
    wait_wb(base + 2);
    if (wbq_rd.size() >= base + 2) begin
      chk("hold_first", {wbq_rd[base], wbq_data[base]}, {5'd20, 16'h003F});
      chk("hold_second", {wbq_rd[base + 1], wbq_data[base + 1]}, {5'd21, 16'h0004});
    end

    // rd=0 result is discarded; the following MULH still writes back
    base = wbq_rd.size();
    p = n_pulse;
    send(3'b011, 16'hFFFF, 16'hFFFF, 5'd0);
    send(3'b001, 16'hFFFF, 16'h0002, 5'd3);
    wait_wb(base + 1);
    repeat (5) @(negedge clk);
    chk("rd0_wb_count", wbq_rd.size() - base, 1);
    if (wbq_rd.size() > base) chk("rd0_next", {wbq_rd[base], wbq_data[base]}, {5'd3, 16'hFFFF});
    chk("rd0_pulses", n_pulse - p, 2);

    // Reset while BUSY drops in-flight and queued work
    send(3'b000, 16'h0002, 16'h0002, 5'd22);
    send(3'b000, 16'h0003, 16'h0003, 5'd23);
    wait_sig("wait_valid_rst", 1);
    base = wbq_rd.size();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_valid_wb", {valid_o, wb_valid_o}, 0);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_regs", {operand_ra_o, operand_rb_o, wb_rd_o, wb_data_o}, 0);
    rst_i = 1'b0;
    p = n_pulse;
    repeat (20) @(negedge clk);
    chk("rst_no_wb", wbq_rd.size() - base, 0);
    chk("rst_fifo_empty", n_pulse - p, 0);
    send(3'b000, 16'h0011, 16'h0003, 5'd24);
    wait_wb(base + 1);
    if (wbq_rd.size() > base) chk("post_rst_mul", {wbq_rd[base], wbq_data[base]}, {5'd24, 16'h0033});

    chk("protocol_violations", n_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
